// File: rtl/kds_pkg.sv
// Shared definitions for the kernel distributor sequencer: FSM state
// encoding, control-word width and the {trc, bank} packing helper that the
// distributor must also use so both sides agree on field order.
package kds_pkg;

  localparam int DEPTH_DEFAULT   = 3;
  localparam int ROUND_W_DEFAULT = 8;
  localparam int CTRL_W          = 2 * DEPTH_DEFAULT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Packs trc above bank; d is the width of each field. Callers truncate the
  // result to 2*d bits.
  function automatic logic [31:0] pack_ctrl(input int d,
                                            input logic [31:0] trc,
                                            input logic [31:0] bank);
    return (trc << d) | bank;
  endfunction

endpackage

// File: rtl/kernel_dist_sequencer_if.sv
// Valid/ready beat channel carrying the {trc, bank} control word from the
// sequencer (master) to the PE-array load logic (slave).
interface kernel_dist_sequencer_if #(
  parameter int depth = 3
);

  logic                 ctrl_valid;
  logic                 ctrl_ready;
  logic [2*depth-1:0]   control_signal;

  modport master (
    output ctrl_valid,
    output control_signal,
    input  ctrl_ready
  );

  modport slave (
    input  ctrl_valid,
    input  control_signal,
    output ctrl_ready
  );

endinterface

// File: rtl/kds_beat_counter.sv
// Bank/round walker. Bank counts 0..bank_last and wraps into the next round;
// the owner decides when to stop, so the counter itself never saturates.
module kds_beat_counter #(
  parameter int depth   = 3,
  parameter int ROUND_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clear,
  input  logic               step,
  input  logic [depth-1:0]   bank_last,
  input  logic [ROUND_W-1:0] rounds,
  output logic [depth-1:0]   bank,
  output logic               last_bank,
  output logic               last_round
);

  logic [ROUND_W-1:0] round;

  assign last_bank  = (bank == bank_last);
  assign last_round = (round == rounds - ROUND_W'(1));

  // Advance bank, rolling into the next round after bank_last.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bank  <= '0;
      round <= '0;
    end else if (clear) begin
      bank  <= '0;
      round <= '0;
    end else if (step) begin
      if (last_bank) begin
        bank  <= '0;
        round <= round + ROUND_W'(1);
      end else begin
        bank  <= bank + depth'(1);
      end
    end
  end

endmodule

// File: rtl/kernel_dist_sequencer.sv
// Kernel distributor sequencer: walks banks 0..bank_last for cfg_rounds
// passes, issuing one {trc, bank} beat per handshake, then pulses done.
// Optional build macro KDS_PERF_CNT_EN adds the stall_cycles counter port.
module kernel_dist_sequencer
  import kds_pkg::*;
#(
  parameter int depth   = DEPTH_DEFAULT,
  parameter int ROUND_W = ROUND_W_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     start,
  input  logic                     abort,
  input  logic [depth-1:0]         cfg_trc,
  input  logic [depth-1:0]         cfg_bank_last,
  input  logic [ROUND_W-1:0]       cfg_rounds,
  kernel_dist_sequencer_if.master  ctrl,
  output logic                     busy,
  output logic                     done
`ifdef KDS_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int CW = 2 * depth;

  state_t             state, state_nx;
  logic [depth-1:0]   trc_q;
  logic [depth-1:0]   bank_last_q;
  logic [ROUND_W-1:0] rounds_q;

  logic [depth-1:0]   bank;
  logic               last_bank;
  logic               last_round;
  logic               cnt_clear;
  logic               cnt_step;
  logic               accept_start;
  logic               transfer;

  assign accept_start = (state == IDLE) && start && !abort;
  assign transfer     = (state == ISSUE) && ctrl.ctrl_ready;

  kds_beat_counter #(
    .depth   (depth),
    .ROUND_W (ROUND_W)
  ) u_beat_counter (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clear      (cnt_clear),
    .step       (cnt_step),
    .bank_last  (bank_last_q),
    .rounds     (rounds_q),
    .bank       (bank),
    .last_bank  (last_bank),
    .last_round (last_round)
  );

  // Capture the sequence configuration only on an accepted start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      trc_q       <= '0;
      bank_last_q <= '0;
      rounds_q    <= '0;
    end else if (accept_start) begin
      trc_q       <= cfg_trc;
      bank_last_q <= cfg_bank_last;
      rounds_q    <= cfg_rounds;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and counter control; abort outranks every transfer decision.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nx  = state;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (accept_start) state_nx = (cfg_rounds == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (abort) begin
          state_nx  = IDLE;
          cnt_clear = 1'b1;
        end else if (transfer) begin
          if (last_bank && last_round) begin
            state_nx  = FINISH;
            cnt_clear = 1'b1;
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
      FINISH: begin
        cnt_clear = 1'b1;
        state_nx  = IDLE;
      end
      default: begin
        cnt_clear = 1'b1;
        state_nx  = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state and held counters, so the word is
  // stable for as long as the beat is stalled.
  assign ctrl.ctrl_valid     = (state == ISSUE);
  assign ctrl.control_signal = (state == ISSUE)
                             ? CW'(pack_ctrl(depth, 32'(trc_q), 32'(bank)))
                             : '0;
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

`ifdef KDS_PERF_CNT_EN
  // Count stalled ISSUE cycles, saturating; cleared only by a new start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cycles <= '0;
    end else if (accept_start) begin
      stall_cycles <= '0;
    end else if ((state == ISSUE) && !ctrl.ctrl_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_dist_sequencer.sv
// Directed self-checking bench for kernel_dist_sequencer. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_kernel_dist_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start;
  logic       abort;
  logic [2:0] cfg_trc;
  logic [2:0] cfg_bank_last;
  logic [7:0] cfg_rounds;
  logic       ready;
  logic       busy;
  logic       done;
`ifdef KDS_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  kernel_dist_sequencer_if #(.depth(3)) ctrl_bus ();
  assign ctrl_bus.ctrl_ready = ready;

  kernel_dist_sequencer #(
    .depth   (3),
    .ROUND_W (8)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .start         (start),
    .abort         (abort),
    .cfg_trc       (cfg_trc),
    .cfg_bank_last (cfg_bank_last),
    .cfg_rounds    (cfg_rounds),
    .ctrl          (ctrl_bus),
    .busy          (busy),
    .done          (done)
`ifdef KDS_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    RST_N = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    cfg_trc = '0; cfg_bank_last = '0; cfg_rounds = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({ctrl_bus.ctrl_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got valid/busy/done=%b exp=000",
               {ctrl_bus.ctrl_valid, busy, done});
    end
    checks++;
    if (ctrl_bus.control_signal !== 6'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000", ctrl_bus.control_signal);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_basic_walk();
    int busy_cnt = 0;
    logic [5:0] exp;
    cfg_trc = 3'b101; cfg_bank_last = 3'd7; cfg_rounds = 8'd1;
    ready = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cfg_trc = 3'b000;  // must be ignored once the sequence runs
    for (int i = 0; i < 8; i++) begin
      exp = {3'b101, 3'(i)};
      checks++;
      if ({ctrl_bus.ctrl_valid, ctrl_bus.control_signal, done} !== {1'b1, exp, 1'b0}) begin
        errors++;
        $display("FAIL walk_beat%0d got valid=%b ctrl=%b done=%b exp valid=1 ctrl=%b done=0",
                 i, ctrl_bus.ctrl_valid, ctrl_bus.control_signal, done, exp);
      end
      if (busy) busy_cnt++;
      @(negedge CLK);
    end
    checks++;
    if ({done, ctrl_bus.ctrl_valid, ctrl_bus.control_signal} !== {1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL walk_done got done=%b valid=%b ctrl=%b exp done=1 valid=0 ctrl=0",
               done, ctrl_bus.ctrl_valid, ctrl_bus.control_signal);
    end
    if (busy) busy_cnt++;
    @(negedge CLK);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL walk_idle got done/busy=%b exp=00", {done, busy});
    end
    checks++;
    if (busy_cnt !== 9) begin
      errors++;
      $display("FAIL walk_busy_cycles got=%0d exp=9", busy_cnt);
    end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    int stalls = 0;
    int dones = 0;
    logic stalled_prev = 1'b0;
    logic tog = 1'b1;
    logic seen_done = 1'b0;
    logic [5:0] prev_cs = '0;
    cfg_trc = 3'b010; cfg_bank_last = 3'd2; cfg_rounds = 8'd3;
    ready = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      if (ctrl_bus.ctrl_valid) begin
        if (stalled_prev) begin
          checks++;
          if (ctrl_bus.control_signal !== prev_cs) begin
            errors++;
            $display("FAIL bp_hold got=%b exp=%b", ctrl_bus.control_signal, prev_cs);
          end
        end
        ready = tog;
        if (tog) begin
          checks++;
          if (ctrl_bus.control_signal !== {3'b010, 3'(beats % 3)}) begin
            errors++;
            $display("FAIL bp_beat%0d got=%b exp=%b", beats,
                     ctrl_bus.control_signal, {3'b010, 3'(beats % 3)});
          end
          beats++;
        end else begin
          stalls++;
        end
        stalled_prev = !tog;
        prev_cs = ctrl_bus.control_signal;
        tog = !tog;
      end else begin
        ready = 1'b1;
        if (done) begin
          dones++;
          seen_done = 1'b1;
        end
      end
      if (!seen_done) @(negedge CLK);
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL bp_timeout got done=0 exp done within 40 cycles");
    end
    checks++;
    if (beats !== 9) begin
      errors++;
      $display("FAIL bp_beats got=%0d exp=9", beats);
    end
    @(negedge CLK);
    checks++;
    if ({done, busy, dones} !== {1'b0, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL bp_single_done got done=%b busy=%b pulses=%0d exp 0 0 1", done, busy, dones);
    end
`ifdef KDS_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'(stalls)) begin
      errors++;
      $display("FAIL bp_stall_cycles got=%0d exp=%0d", stall_cycles, stalls);
    end
`endif
  endtask

  task automatic test_zero_rounds();
    cfg_trc = 3'b111; cfg_bank_last = 3'd4; cfg_rounds = 8'd0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if ({ctrl_bus.ctrl_valid, done, busy} !== 3'b011) begin
      errors++;
      $display("FAIL zero_finish got valid/done/busy=%b exp=011",
               {ctrl_bus.ctrl_valid, done, busy});
    end
    @(negedge CLK);
    checks++;
    if ({ctrl_bus.ctrl_valid, done, busy} !== 3'b000) begin
      errors++;
      $display("FAIL zero_idle got valid/done/busy=%b exp=000",
               {ctrl_bus.ctrl_valid, done, busy});
    end
  endtask

  task automatic test_abort();
    cfg_trc = 3'b011; cfg_bank_last = 3'd7; cfg_rounds = 8'd2;
    ready = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ctrl_bus.control_signal !== {3'b011, 3'(i)}) begin
        errors++;
        $display("FAIL abort_pre%0d got=%b exp=%b", i, ctrl_bus.control_signal, {3'b011, 3'(i)});
      end
      @(negedge CLK);
    end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checks++;
    if ({ctrl_bus.ctrl_valid, busy, done, ctrl_bus.control_signal} !== 9'd0) begin
      errors++;
      $display("FAIL abort_idle got valid=%b busy=%b done=%b ctrl=%b exp all 0",
               ctrl_bus.ctrl_valid, busy, done, ctrl_bus.control_signal);
    end
    @(negedge CLK);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_done got busy/done=%b exp=00", {busy, done});
    end
    // abort and start together in IDLE: nothing starts
    start = 1'b1; abort = 1'b1;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, ctrl_bus.ctrl_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_wins_start got busy/valid=%b exp=00", {busy, ctrl_bus.ctrl_valid});
    end
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({ctrl_bus.ctrl_valid, ctrl_bus.control_signal} !== {1'b1, 3'b011, 3'(i % 8)}) begin
        errors++;
        $display("FAIL rerun_beat%0d got valid=%b ctrl=%b exp valid=1 ctrl=%b", i,
                 ctrl_bus.ctrl_valid, ctrl_bus.control_signal, {3'b011, 3'(i % 8)});
      end
      @(negedge CLK);
    end
    checks++;
    if ({done, ctrl_bus.ctrl_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rerun_done got done/valid=%b exp=10", {done, ctrl_bus.ctrl_valid});
    end
    @(negedge CLK);
  endtask

  task automatic test_start_while_busy();
    int beats = 0;
    logic seen_done = 1'b0;
    cfg_trc = 3'b110; cfg_bank_last = 3'd3; cfg_rounds = 8'd1;
    ready = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
      start = 1'b0;
      if (ctrl_bus.ctrl_valid) begin
        beats++;
        if (beats == 2) begin
          start = 1'b1;
          cfg_rounds = 8'd5;
        end
      end
      if (done) seen_done = 1'b1;
      else      @(negedge CLK);
    end
    start = 1'b0;
    checks++;
    if (!seen_done || beats != 4) begin
      errors++;
      $display("FAIL busy_start_beats got beats=%0d done_seen=%b exp beats=4 done_seen=1",
               beats, seen_done);
    end
    @(negedge CLK);
    checks++;
    if ({busy, ctrl_bus.ctrl_valid} !== 2'b00) begin
      errors++;
      $display("FAIL busy_start_not_queued got busy/valid=%b exp=00", {busy, ctrl_bus.ctrl_valid});
    end
  endtask

  task automatic test_reset_mid_op();
    cfg_trc = 3'b101; cfg_bank_last = 3'd7; cfg_rounds = 8'd1;
    ready = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctrl_bus.control_signal !== 6'b101001) begin
      errors++;
      $display("FAIL rst_pre got=%b exp=101001", ctrl_bus.control_signal);
    end
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if ({ctrl_bus.ctrl_valid, busy, done, ctrl_bus.control_signal} !== 9'd0) begin
      errors++;
      $display("FAIL rst_async got valid=%b busy=%b done=%b ctrl=%b exp all 0",
               ctrl_bus.ctrl_valid, busy, done, ctrl_bus.control_signal);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ctrl_bus.ctrl_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_after got valid/busy/done=%b exp=000",
               {ctrl_bus.ctrl_valid, busy, done});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish exp finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_walk();
    test_backpressure();
    test_zero_rounds();
    test_abort();
    test_start_while_busy();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kernel_dist_sequencer.md
Name: kernel_dist_sequencer

Overview:
- Sequences the combinational kernel buffer distributor by generating its {trc, bank} control word, one beat at a time.
- Beats are issued over a valid/ready handshake to the PE-array load logic.
- Software programs a transpose/rotate code (trc), a last bank index and a round count, then pulses start.
- The block walks banks 0..bank_last for the requested number of rounds and then signals done.

Parameters:
- depth, 3, log2 of bank/lane count; the control word is 2*depth bits.
- ROUND_W, 8, width of the round counter and cfg_rounds.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sequence; sampled only in IDLE.
- abort  input  1  synchronous cancel; highest priority after reset.
- cfg_trc  input  depth  trc field, held for the whole sequence.
- cfg_bank_last  input  depth  last bank index per round (0..2^depth-1).
- cfg_rounds  input  ROUND_W  number of passes over the banks.
- ctrl_valid  output  1  control_signal holds a valid beat.
- ctrl_ready  input  1  downstream accepts the beat.
- control_signal  output  2*depth  {trc, bank} word fed to the distributor.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; ctrl_valid=0, control_signal=0, busy=0, done=0; all counters and config latches = 0.
- States are IDLE, ISSUE, FINISH.
- IDLE:
  - On start=1, latch cfg_trc, cfg_bank_last and cfg_rounds.
  - If cfg_rounds==0, go to FINISH; no beat is issued.
  - Otherwise go to ISSUE with bank=0 and round=0.
  - Config inputs are ignored outside the start cycle.
- Start latency: the first ctrl_valid is asserted in the cycle after start.
- ISSUE:
  - ctrl_valid=1 and control_signal={trc_latched, bank}.
  - A beat transfers on a cycle where ctrl_valid && ctrl_ready.
  - On a transfer with bank<bank_last: bank+1.
  - On a transfer with bank==bank_last: bank=0, round+1.
  - If that was the last round (round==rounds-1), go to FINISH instead.
  - Back-to-back transfers sustain 1 beat/cycle.
  - Without ctrl_ready, ctrl_valid and control_signal hold stable (AXI-style; the value never changes while stalled).
- FINISH: done=1 for exactly one cycle, ctrl_valid=0, then IDLE. busy stays high in FINISH and drops in the next cycle.
- Total beats per sequence = (bank_last+1)*rounds. The bank counter never exceeds bank_last, and depth-bit wrap is impossible by construction.
- start while busy: ignored; it is not queued.
- abort=1 in any non-IDLE state: next state IDLE, ctrl_valid=0, no done pulse, counters cleared.
  - abort on the same cycle as a transfer: the transfer counts downstream, but the sequence still aborts.
  - abort in IDLE together with start: abort wins and nothing starts.
- control_signal returns to 0 when entering IDLE.
- RST_N asserted mid-sequence: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: KDS_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0], counting ISSUE cycles with ctrl_valid && !ctrl_ready.
  - Clears on an accepted start and saturates at all-ones.
  - Holds its value after done or abort until the next start.
  - Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package kds_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, FINISH=2'd2);
  - CTRL_W = 2*depth;
  - a helper to pack {trc, bank}.
- The distributor must reuse the same packing order.
- One natural sub-module: kds_beat_counter.
  - It holds the bank/round counters and advances them on a step input.
  - Outputs: bank, last_bank, last_round.

Test Plan:
- Basic walk: trc=3'b101, bank_last=7, rounds=1, ready tied high → 8 beats on consecutive cycles with control_signal 6'b101000..6'b101111. done pulses the cycle after the last beat; busy is high for 9 cycles.
- Multi-round with backpressure: bank_last=2, rounds=3, ready toggling 1/0 → 9 accepted beats in bank order 0,1,2 repeated. control_signal holds stable in every stalled cycle, then one done pulse. With KDS_PERF_CNT_EN defined, stall_cycles equals the number of stalled cycles.
- Zero rounds: rounds=0, start → no ctrl_valid, done in the cycle after start; busy high for exactly 1 cycle.
- Abort: bank_last=7, rounds=2, assert abort after the 5th transfer → ctrl_valid drops next cycle, no done, state IDLE. A following start runs a full 16-beat sequence from bank 0.
- start while busy / reset mid-op: a second start during a sequence has no effect (beat count unchanged). RST_N pulsed low mid-beat clears all outputs to 0 asynchronously without waiting for a CLK edge.
